// File: rtl/clk_mon_pkg.sv
// Shared types and helpers for the pll_clock frequency monitor.
package clk_mon_pkg;

  // Measurement FSM: discard the partial window after reset, then measure every window.
  typedef enum logic {
    WAIT_FIRST = 1'b0,
    RUN        = 1'b1
  } mon_state_t;

  localparam int unsigned CNT_W_DEFAULT = 24;

  // True when count lies within [expected - tol, expected + tol], inclusive.
  // The lower bound clamps at zero so small expected values with large tolerances behave.
  function automatic logic in_range(input logic [31:0] count,
                                    input logic [31:0] expected,
                                    input logic [31:0] tol);
    logic [32:0] lo_b;
    logic [32:0] hi_b;
    hi_b = {1'b0, expected} + {1'b0, tol};
    lo_b = (expected > tol) ? {1'b0, expected - tol} : '0;
    return ({1'b0, count} >= lo_b) && ({1'b0, count} <= hi_b);
  endfunction

endpackage

// File: rtl/clk_freq_monitor_toggle_sync.sv
// Carries the ref-domain window toggle into the pll_clock domain and turns each
// toggle flip into a single-cycle strobe. Latency is fixed at 3-4 pll_clock cycles,
// so it cancels between consecutive window edges.
module toggle_sync (
  input  logic pll_clock,
  input  logic reset,
  input  logic toggle,
  output logic strobe
);

  logic sync1;
  logic sync2;
  logic sync3;

  // Two-flop synchroniser, one history flop for edge detect, registered strobe.
  always_ff @(posedge pll_clock or posedge reset) begin
    if (reset) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      sync3  <= 1'b0;
      strobe <= 1'b0;
    end else begin
      sync1  <= toggle;
      sync2  <= sync1;
      sync3  <= sync2;
      strobe <= sync2 ^ sync3;
    end
  end

endmodule

// File: rtl/clk_freq_monitor.sv
// clk_freq_monitor: counts pll_clock cycles per reference window (ref_clk) and
// reports the count, a per-window valid pulse, high/low range errors, loss of the
// reference (counter saturation) and a qualified freq_ok status.
// Optional build macro STICKY_ERR_EN: err_hi, err_lo and ref_lost latch until reset.
module clk_freq_monitor
  import clk_mon_pkg::*;
#(
  parameter int unsigned REF_WINDOW   = 25000,
  parameter int unsigned EXPECTED_CNT = 10000,
  parameter int unsigned TOLERANCE    = 20,
  parameter int unsigned GOOD_WINDOWS = 3,
  parameter int unsigned CNT_W        = CNT_W_DEFAULT
) (
  input  logic             pll_clock,
  input  logic             reset,
  input  logic             ref_clk,
  output logic [CNT_W-1:0] meas_count,
  output logic             meas_valid,
  output logic             freq_ok,
  output logic             err_hi,
  output logic             err_lo,
  output logic             ref_lost
);

  localparam int unsigned REF_W  = (REF_WINDOW > 1) ? $clog2(REF_WINDOW) : 1;
  localparam int unsigned GOOD_W = (GOOD_WINDOWS > 0) ? $clog2(GOOD_WINDOWS + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // ---------------------------------------------------------------- ref domain
  logic [REF_W-1:0] ref_cnt;
  logic             ref_toggle;

  // Window generator: count 0..REF_WINDOW-1 and flip the toggle on every wrap.
  always_ff @(posedge ref_clk or posedge reset) begin
    if (reset) begin
      ref_cnt    <= '0;
      ref_toggle <= 1'b0;
    end else if (ref_cnt == REF_W'(REF_WINDOW - 1)) begin
      ref_cnt    <= '0;
      ref_toggle <= ~ref_toggle;
    end else begin
      ref_cnt    <= ref_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------- crossing
  logic strobe;

  toggle_sync u_toggle_sync (
    .pll_clock (pll_clock),
    .reset     (reset),
    .toggle    (ref_toggle),
    .strobe    (strobe)
  );

  // ---------------------------------------------------------------- FSM
  mon_state_t state;
  mon_state_t state_nxt;
  logic       start_window;
  logic       window_end;
  logic       run;

  // State register.
  always_ff @(posedge pll_clock or posedge reset) begin
    if (reset) begin
      state <= WAIT_FIRST;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: the first strobe after reset opens the first full window.
  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_FIRST: if (strobe) state_nxt = RUN;
      RUN:        state_nxt = RUN;
      default:    state_nxt = WAIT_FIRST;
    endcase
  end

  // FSM outputs: window start/end qualifiers and counting enable.
  always_comb begin
    start_window = 1'b0;
    window_end   = 1'b0;
    run          = 1'b0;
    case (state)
      WAIT_FIRST: start_window = strobe;
      RUN: begin
        run        = 1'b1;
        window_end = strobe;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------- counter
  logic [CNT_W-1:0] pll_cnt;
  logic             cnt_sat;

  assign cnt_sat = (pll_cnt == CNT_MAX);

  // pll_clock cycle counter: the strobe cycle is the first cycle of the new window,
  // hence the reload to 1; holds at all-ones when no window edge arrives.
  always_ff @(posedge pll_clock or posedge reset) begin
    if (reset) begin
      pll_cnt <= '0;
    end else if (start_window || window_end) begin
      pll_cnt <= CNT_W'(1);
    end else if (run && !cnt_sat) begin
      pll_cnt <= pll_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------- compare
  logic win_in_range;
  logic win_hi;
  logic win_lo;

  // Range classification of the window that is closing; exactly one of the three holds.
  always_comb begin
    win_in_range = in_range(32'(pll_cnt), 32'(EXPECTED_CNT), 32'(TOLERANCE));
    win_hi       = !win_in_range && (32'(pll_cnt) > 32'(EXPECTED_CNT));
    win_lo       = !win_in_range && !win_hi;
  end

  // Measurement capture: count and valid pulse appear together after the strobe cycle.
  always_ff @(posedge pll_clock or posedge reset) begin
    if (reset) begin
      meas_count <= '0;
      meas_valid <= 1'b0;
    end else begin
      meas_valid <= window_end;
      if (window_end) begin
        meas_count <= pll_cnt;
      end
    end
  end

  // ---------------------------------------------------------------- status
  logic [GOOD_W-1:0] good_cnt;

  // Consecutive in-range window counter, saturating; cleared by a bad window or saturation.
  always_ff @(posedge pll_clock or posedge reset) begin
    if (reset) begin
      good_cnt <= '0;
    end else if (window_end) begin
      if (!win_in_range) begin
        good_cnt <= '0;
      end else if (good_cnt != GOOD_W'(GOOD_WINDOWS)) begin
        good_cnt <= good_cnt + 1'b1;
      end
    end else if (run && cnt_sat) begin
      good_cnt <= '0;
    end
  end

  assign freq_ok = (good_cnt == GOOD_W'(GOOD_WINDOWS));

  // Error flags: range errors from the closing window, ref_lost from counter saturation.
  always_ff @(posedge pll_clock or posedge reset) begin
    if (reset) begin
      err_hi   <= 1'b0;
      err_lo   <= 1'b0;
      ref_lost <= 1'b0;
    end else if (window_end) begin
`ifdef STICKY_ERR_EN
      err_hi   <= err_hi | win_hi;
      err_lo   <= err_lo | win_lo;
      ref_lost <= ref_lost | cnt_sat;
`else
      err_hi   <= win_hi;
      err_lo   <= win_lo;
      // A strobe normally clears ref_lost, but saturation first reached on the strobe
      // cycle itself has not been reported yet, so it is raised for this window instead.
      ref_lost <= cnt_sat && !ref_lost;
`endif
    end else if (run && cnt_sat) begin
      ref_lost <= 1'b1;
    end
  end

endmodule
